// File: rtl/shift_sched_if.sv
// Request/grant/result bundle between two requesters and the shared shift engine.
interface shift_sched_if #(
  parameter int WIDTH = 8,
  parameter int AMTW  = 8
);
  logic             req0, req1;
  logic [WIDTH-1:0] data0, data1;
  logic [AMTW-1:0]  amt0, amt1;
  logic             dir0, dir1;
  logic             gnt0, gnt1;
  logic             done0, done1;
  logic [WIDTH-1:0] result;
  logic             busy;

  modport slave (
    input  req0, req1, data0, data1, amt0, amt1, dir0, dir1,
    output gnt0, gnt1, done0, done1, result, busy
  );

  modport master (
    output req0, req1, data0, data1, amt0, amt1, dir0, dir1,
    input  gnt0, gnt1, done0, done1, result, busy
  );
endinterface

// File: rtl/shift_sched.sv
// Round-robin shared one-bit-per-clock shift engine for two requesters.
// Define SHIFT_SCHED_RIGHT_EN to honour dirN (1 = logical right); otherwise all shifts are left.
module shift_sched #(
  parameter int WIDTH = 8,
  parameter int AMTW  = 8
) (
  input logic          clk,
  input logic          reset,
  shift_sched_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] work_q, work_d, result_q;
  logic [CW-1:0]    cnt_q;
  logic             owner_q, ptr_q;
  logic             gnt0_q, gnt1_q, done0_q, done1_q, busy_q;

  logic             win;
  logic [WIDTH-1:0] win_data;
  logic [AMTW-1:0]  win_amt;
  logic [CW-1:0]    win_cnt;

`ifdef SHIFT_SCHED_RIGHT_EN
  logic dir_q;
  logic win_dir;
  assign win_dir = win ? bus.dir1 : bus.dir0;
  assign work_d  = dir_q ? (work_q >> 1) : (work_q << 1);
`else
  logic unused_dir;
  assign unused_dir = bus.dir0 ^ bus.dir1;
  assign work_d     = work_q << 1;
`endif

  // ptr_q holds the last requester served; on a tie the other one wins.
  always_comb begin
    win      = (bus.req0 && bus.req1) ? ~ptr_q : bus.req1;
    win_data = win ? bus.data1 : bus.data0;
    win_amt  = win ? bus.amt1 : bus.amt0;
    win_cnt  = (32'(win_amt) >= WIDTH) ? CW'(WIDTH) : CW'(win_amt);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      work_q   <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      owner_q  <= 1'b0;
      ptr_q    <= 1'b1;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      busy_q   <= 1'b0;
`ifdef SHIFT_SCHED_RIGHT_EN
      dir_q    <= 1'b0;
`endif
    end else begin
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            owner_q <= win;
            work_q  <= win_data;
            cnt_q   <= win_cnt;
`ifdef SHIFT_SCHED_RIGHT_EN
            dir_q   <= win_dir;
`endif
            gnt0_q  <= ~win;
            gnt1_q  <= win;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (cnt_q != '0) begin
            work_q <= work_d;
            cnt_q  <= cnt_q - CW'(1);
          end else begin
            result_q <= work_q;
            done0_q  <= ~owner_q;
            done1_q  <= owner_q;
            state_q  <= DONE;
          end
        end
        DONE: begin
          ptr_q   <= owner_q;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.gnt0   = gnt0_q;
  assign bus.gnt1   = gnt1_q;
  assign bus.done0  = done0_q;
  assign bus.done1  = done1_q;
  assign bus.result = result_q;
  assign bus.busy   = busy_q;
endmodule

// File: tb/tb_shift_sched.sv
// Directed bench for shift_sched: vector table plus arbitration/reset/busy sequences.
module tb_shift_sched;
  localparam int W = 8;
  localparam int A = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;

  shift_sched_if #(.WIDTH(W), .AMTW(A)) bus ();
  shift_sched #(.WIDTH(W), .AMTW(A)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit overlap_seen = 1'b0;
  bit mon_en = 1'b0;
  bit side_seen = 1'b0;

  always @(negedge clk) begin
    if (bus.done0 && bus.done1) overlap_seen = 1'b1;
    if (mon_en && (bus.gnt1 || bus.done1)) side_seen = 1'b1;
  end

  typedef struct {
    bit         sel;
    logic [7:0] data;
    logic [7:0] amt;
    bit         dir;
    logic [7:0] exp_res;
    int         exp_lat;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  function automatic bit sig(input int which);
    case (which)
      0: sig = bus.gnt0;
      1: sig = bus.gnt1;
      2: sig = bus.done0;
      3: sig = bus.done1;
      default: sig = bus.gnt0 | bus.gnt1;
    endcase
  endfunction

  // Count negedges until the selected signal is seen; -1 if the bound expires.
  task automatic wait_evt(input int which, input int bound, output int cyc);
    bit hit;
    hit = 1'b0;
    cyc = 0;
    while (!hit && cyc < bound) begin
      @(negedge clk);
      cyc++;
      hit = sig(which);
    end
    if (!hit) cyc = -1;
  endtask

  task automatic apply(input vec_t v, input string nm);
    int c;
    @(negedge clk);
    if (v.sel) begin
      bus.req1 = 1'b1; bus.data1 = v.data; bus.amt1 = v.amt; bus.dir1 = v.dir;
    end else begin
      bus.req0 = 1'b1; bus.data0 = v.data; bus.amt0 = v.amt; bus.dir0 = v.dir;
    end
    wait_evt(v.sel ? 1 : 0, 20, c);
    check({nm, " gnt"}, 32'(c > 0), 32'd1);
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    wait_evt(v.sel ? 3 : 2, 40, c);
    check({nm, " lat"}, 32'(c), 32'(v.exp_lat));
    check({nm, " res"}, 32'(bus.result), 32'(v.exp_res));
  endtask

  initial begin
    int c;
    bit seen;
    bus.req0 = 0; bus.req1 = 0; bus.data0 = '0; bus.data1 = '0;
    bus.amt0 = '0; bus.amt1 = '0; bus.dir0 = 0; bus.dir1 = 0;

    for (int i = 0; i < 8; i++)
      vecs[i] = '{1'b0, 8'h01, 8'(i), 1'b0, 8'h01 << i, i + 1};
    vecs[8]  = '{1'b1, 8'ha5, 8'h07, 1'b0, 8'h80, 8};
    vecs[9]  = '{1'b1, 8'ha5, 8'h01, 1'b0, 8'h4a, 2};
    vecs[10] = '{1'b1, 8'ha5, 8'h09, 1'b0, 8'h00, 9};
    vecs[11] = '{1'b1, 8'hff, 8'h08, 1'b0, 8'h00, 9};
    vecs[12] = '{1'b0, 8'h3c, 8'hff, 1'b0, 8'h00, 9};
`ifdef SHIFT_SCHED_RIGHT_EN
    vecs[13] = '{1'b0, 8'ha5, 8'h01, 1'b1, 8'h52, 2};
    vecs[14] = '{1'b0, 8'ha5, 8'h07, 1'b1, 8'h01, 8};
`else
    vecs[13] = '{1'b0, 8'ha5, 8'h01, 1'b1, 8'h4a, 2};
    vecs[14] = '{1'b0, 8'ha5, 8'h07, 1'b1, 8'h80, 8};
`endif
    vecs[15] = '{1'b1, 8'h81, 8'h0a, 1'b1, 8'h00, 9};

    // Reset state
    @(negedge clk);
    check("reset outs", 32'({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy, bus.result}), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) apply(vecs[i], $sformatf("v%0d", i));

    // Tie after reset-era pointer: req0 first, then req1, then req0 again
    @(negedge clk);
    bus.req0 = 1; bus.data0 = 8'h01; bus.amt0 = 8'd1; bus.dir0 = 0;
    bus.req1 = 1; bus.data1 = 8'ha5; bus.amt1 = 8'd1; bus.dir1 = 0;
    wait_evt(4, 20, c);
    check("tie1 gnt", 32'({bus.gnt0, bus.gnt1}), 32'b10);
    bus.req0 = 0;
    wait_evt(2, 40, c);
    check("tie1 res0", 32'(bus.result), 32'h02);
    wait_evt(1, 20, c);
    check("tie1 gnt1 next", 32'(c > 0), 32'd1);
    bus.req1 = 0;
    wait_evt(3, 40, c);
    check("tie1 res1", 32'(bus.result), 32'h4a);
    @(negedge clk);
    bus.req0 = 1; bus.req1 = 1;
    wait_evt(4, 20, c);
    check("tie2 gnt", 32'({bus.gnt0, bus.gnt1}), 32'b10);
    bus.req0 = 0; bus.req1 = 0;
    wait_evt(2, 40, c);
    check("tie2 res0", 32'(bus.result), 32'h02);

    // Reset mid-SHIFT
    @(negedge clk);
    bus.req0 = 1; bus.data0 = 8'ha5; bus.amt0 = 8'd7;
    wait_evt(0, 20, c);
    bus.req0 = 0;
    repeat (3) @(negedge clk);
    check("midshift busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    #1;
    check("async reset outs", 32'({bus.gnt0, bus.gnt1, bus.done0, bus.done1, bus.busy, bus.result}), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done0 || bus.done1 || bus.busy) seen = 1'b1;
    end
    check("no done after reset", 32'(seen), 32'd0);
    bus.req0 = 1; bus.req1 = 1; bus.data0 = 8'h01; bus.amt0 = 8'd2;
    wait_evt(4, 20, c);
    check("post-reset tie gnt", 32'({bus.gnt0, bus.gnt1}), 32'b10);
    bus.req0 = 0; bus.req1 = 0;
    wait_evt(2, 40, c);
    check("post-reset res", 32'(bus.result), 32'h04);

    // req1 pulsed while busy serving req0 is dropped
    @(negedge clk);
    bus.req0 = 1; bus.data0 = 8'h01; bus.amt0 = 8'd5;
    wait_evt(0, 20, c);
    bus.req0 = 0;
    mon_en = 1'b1;
    @(negedge clk);
    bus.req1 = 1;
    repeat (2) @(negedge clk);
    bus.req1 = 0;
    wait_evt(2, 40, c);
    check("busy res0", 32'(bus.result), 32'h20);
    repeat (6) @(negedge clk);
    mon_en = 1'b0;
    check("ignored req1", 32'(side_seen), 32'd0);

    check("done overlap", 32'(overlap_seen), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/shift_sched.md
# shift_sched

Sequential shift controller that shares one iterative shift engine between two requesters. Each accepted request shifts its operand by a variable amount, one bit position per clock, and returns the result with a done pulse to the requester that issued it. Fairness is round-robin. The block sits in the arithmetic-support layer beside the variable-shift datapath and replaces per-client barrel shifters where latency is acceptable.

## Interface
- WIDTH, 8, operand/result width
- AMTW, 8, shift-amount width
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req0, req1  in  1  request level, held until matching gnt seen
- data0, data1  in  WIDTH  operand per requester
- amt0, amt1  in  AMTW  unsigned shift amount per requester
- dir0, dir1  in  1  0 = left, 1 = right (see Configuration)
- gnt0, gnt1  out  1  one-cycle accept pulse
- done0, done1  out  1  one-cycle result-valid pulse
- result  out  WIDTH  shifted value, valid while doneN high, held afterwards
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: at an edge with req0 or req1 high, pick the winner, then:
  - latch data, dir, owner and cnt = min(amt, WIDTH);
  - go to SHIFT; gntN is high for the following cycle.
- Arbitration:
  - single requester wins outright;
  - both high: winner is the requester not served last;
  - pointer resets so req0 wins the first tie.
- SHIFT, each edge:
  - cnt != 0: shift the working register one bit (zero fill), cnt--;
  - cnt == 0: load result, go to DONE.
- DONE: doneN for the owner is high this cycle; the next edge returns to IDLE and updates the pointer to the owner.
- Amounts >= WIDTH clamp to WIDTH shifts, so result = 0 (e.g. 8'h09 on WIDTH 8).
- Results are logical only; no sign extension.
- Requester protocol:
  - drop req, or present the next operand, by the edge after gnt;
  - a req still high when the block returns to IDLE is treated as a new request;
  - withdrawing req before gnt is legal and has no effect.
- A req arriving while busy is ignored until IDLE; there is no queueing.

## Timing
- Accept edge E0. gnt is high in cycle E0..E1.
- Shift edges E1..Ecnt. Edge Ecnt+1 enters DONE.
- doneN is high in cycle Ecnt+1..Ecnt+2, i.e. cnt+1 cycles after the gnt cycle.
  - amt 0: done follows gnt by exactly 1 cycle.
  - amt 7: 8 cycles.
- Earliest next accept is edge Ecnt+3. Occupancy is cnt+3 cycles per request.
- reset, asynchronous, at any time:
  - state IDLE; gnt0, gnt1, done0, done1, busy = 0; result = 0;
  - pointer favours req0;
  - an in-flight operation is discarded with no done pulse.
- After reset deassertion, the first accept happens at the first edge with a req high.

## Configuration
- SHIFT_SCHED_RIGHT_EN defined: dirN = 1 selects a logical right shift, with the same latency and clamping rules as left.
- Not defined:
  - dir0 and dir1 are ignored and all shifts are left;
  - the dir ports remain present, and no direction register is synthesized.

## Test plan
- req0, data0=8'h01, amt0 stepping 0..7 -> done0 results 01, 02, 04, 08, 10, 20, 40, 80; done follows gnt by amt+1 cycles.
- req1, data1=8'ha5: amt1=7 -> 8'h80; amt1=1 -> 8'h4a; amt1=8'h09 -> 8'h00 after WIDTH+1 cycles.
- req0 and req1 high on the same edge after reset -> req0 granted first, req1 granted at the next IDLE; a repeated tie then grants req0 (alternation). done0 and done1 never coincide.
- reset asserted mid-SHIFT (data 8'ha5, amt 7) -> all outputs 0 immediately, no done pulse, next tie grants req0.
- With SHIFT_SCHED_RIGHT_EN: dir0=1, data 8'ha5, amt 1 -> 8'h52; amt 7 -> 8'h01. Without the macro, the same stimulus -> 8'h4a and 8'h80.
- req1 raised then dropped while busy serving req0 -> no gnt1, no done1.
